ysyx_24090018_ifu: RTL and testbench

- Instruction fetch unit for the NPC core: owns the PC and issues one fetch per instruction over a valid/ready instruction-memory port.
- Holds the returned instruction and hands it downstream to the decoder with a valid/ready handshake.
- Loads the next PC from the write-back/next-PC logic; feeds IDU, consumes the NPC result.
- Strictly one outstanding fetch.

---
 rtl/ysyx_24090018_ifu_pkg.sv | 25 ++
 rtl/ysyx_24090018_ifu_reg.sv | 30 +++
 rtl/ysyx_24090018_ifu.sv | 184 ++++++++++++++++++
 tb/tb_ysyx_24090018_ifu.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24090018_ifu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24090018_ifu_pkg
//   Shared definitions for the NPC instruction fetch unit:
//     - ifu_state_e : IFU FSM state encoding (2 bits)
//     - fetch_err_e : fetch status codes reported alongside each instruction
//     - IFU_RESET_PC: default PC after reset
// ---------------------------------------------------------------------------
package ysyx_24090018_ifu_pkg;

  typedef enum logic [1:0] {
    IFU_REQ      = 2'd0,
    IFU_WAIT_RSP = 2'd1,
    IFU_OUT      = 2'd2,
    IFU_WAIT_NPC = 2'd3
  } ifu_state_e;

  typedef enum logic [1:0] {
    FE_OK       = 2'b00,
    FE_BUS      = 2'b01,
    FE_MISALIGN = 2'b10
  } fetch_err_e;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_24090018_ifu_reg.sv
// ---------------------------------------------------------------------------
// ysyx_24090018_ifu_reg
//   Generic enable register with synchronous, active-high reset.
//   Ports:
//     i_clk  : clock, all updates on posedge
//     i_rst  : synchronous reset, active high, loads RESET_VAL
//     i_wen  : write enable
//     i_din  : data in  [WIDTH-1:0]
//     o_dout : registered data out [WIDTH-1:0]
// ---------------------------------------------------------------------------
module ysyx_24090018_ifu_reg #(
  parameter int unsigned            WIDTH     = 1,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wen,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_dout <= RESET_VAL;
    end else if (i_wen) begin
      o_dout <= i_din;
    end
  end

endmodule

// File: rtl/ysyx_24090018_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_24090018_ifu
//   Instruction fetch unit: owns the PC, issues exactly one outstanding fetch
//   over a valid/ready instruction-memory port, holds the returned instruction
//   for the IDU (valid/ready), then waits for the next PC.
//
//   Ports:
//     clk, rst            : clock; synchronous active-low reset
//     npc_valid_i/npc_i   : next PC from write-back / next-PC logic
//     npc_ready_o         : IFU accepts next PC (WAIT_NPC)
//     imem_req_valid_o/imem_req_ready_i/imem_addr_o : fetch request
//     imem_rsp_valid_i/imem_rsp_data_i/imem_rsp_err_i : fetch response
//     inst_valid_o/inst_ready_i/inst_o/pc_o/fetch_err_o : to IDU
//
//   Optional feature (macro YSYX_24090018_IFU_PERF_EN):
//     perf_fetch_cnt_o : count of instructions handed to the IDU
//     perf_stall_cnt_o : cycles in REQ without req_ready, or in WAIT_RSP
// ---------------------------------------------------------------------------
module ysyx_24090018_ifu
  import ysyx_24090018_ifu_pkg::*;
#(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         DATA_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              npc_valid_i,
  input  logic [ADDR_W-1:0] npc_i,
  output logic              npc_ready_o,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [DATA_W-1:0] imem_rsp_data_i,
  input  logic              imem_rsp_err_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [1:0]        fetch_err_o
`ifdef YSYX_24090018_IFU_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt_o,
  output logic [31:0]       perf_stall_cnt_o
`endif
);

  ifu_state_e        r_state;
  ifu_state_e        w_state_nxt;

  logic [ADDR_W-1:0] w_pc;
  logic              w_pc_we;
  logic              w_misalign;

  logic              w_req_valid;
  logic              w_inst_valid;
  logic              w_npc_ready;

  logic              w_hold_we;
  logic [DATA_W+1:0] w_hold_d;
  logic [DATA_W+1:0] w_hold_q;

  logic              w_rst_hi;

  assign w_rst_hi   = ~rst;
  assign w_misalign = |w_pc[1:0];

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IFU_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, handshake outputs and holding-register load
  always_comb begin
    w_state_nxt  = r_state;
    w_req_valid  = 1'b0;
    w_inst_valid = 1'b0;
    w_npc_ready  = 1'b0;
    w_hold_we    = 1'b0;
    w_hold_d     = '0;
    w_pc_we      = 1'b0;
    unique case (r_state)
      IFU_REQ: begin
        if (w_misalign) begin
          // Misaligned PC never reaches memory; report it as a fetch result.
          w_hold_we   = 1'b1;
          w_hold_d    = {FE_MISALIGN, {DATA_W{1'b0}}};
          w_state_nxt = IFU_OUT;
        end else begin
          w_req_valid = 1'b1;
          if (imem_req_ready_i) begin
            w_state_nxt = IFU_WAIT_RSP;
          end
        end
      end
      IFU_WAIT_RSP: begin
        if (imem_rsp_valid_i) begin
          w_hold_we   = 1'b1;
          w_hold_d    = {(imem_rsp_err_i ? FE_BUS : FE_OK), imem_rsp_data_i};
          w_state_nxt = IFU_OUT;
        end
      end
      IFU_OUT: begin
        w_inst_valid = 1'b1;
        if (inst_ready_i) begin
          w_state_nxt = IFU_WAIT_NPC;
        end
      end
      IFU_WAIT_NPC: begin
        w_npc_ready = 1'b1;
        if (npc_valid_i) begin
          w_pc_we     = 1'b1;
          w_state_nxt = IFU_REQ;
        end
      end
      default: begin
        w_state_nxt = IFU_REQ;
      end
    endcase
  end

  // PC storage
  ysyx_24090018_ifu_reg #(
    .WIDTH     (ADDR_W),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .i_clk  (clk),
    .i_rst  (w_rst_hi),
    .i_wen  (w_pc_we),
    .i_din  (npc_i),
    .o_dout (w_pc)
  );

  // Instruction + fetch status holding register: {fetch_err, inst}
  ysyx_24090018_ifu_reg #(
    .WIDTH     (DATA_W + 2),
    .RESET_VAL ('0)
  ) u_hold_reg (
    .i_clk  (clk),
    .i_rst  (w_rst_hi),
    .i_wen  (w_hold_we),
    .i_din  (w_hold_d),
    .o_dout (w_hold_q)
  );

  // Handshake outputs are forced low while reset is asserted, regardless of
  // whatever state the FSM held before the reset edge.
  assign imem_req_valid_o = w_req_valid  & rst;
  assign inst_valid_o     = w_inst_valid & rst;
  assign npc_ready_o      = w_npc_ready  & rst;

  assign imem_addr_o = w_pc;
  assign pc_o        = w_pc;
  assign inst_o      = w_hold_q[DATA_W-1:0];
  assign fetch_err_o = w_hold_q[DATA_W +: 2];

`ifdef YSYX_24090018_IFU_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (r_state == IFU_OUT && inst_ready_i) begin
        r_perf_fetch <= r_perf_fetch + 32'd1;
      end
      if ((r_state == IFU_REQ && !imem_req_ready_i) || r_state == IFU_WAIT_RSP) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt_o = r_perf_fetch;
  assign perf_stall_cnt_o = r_perf_stall;
`endif

endmodule

// File: tb/tb_ysyx_24090018_ifu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24090018_ifu
//   Self-checking bench for the instruction fetch unit. The bench plays the
//   instruction memory, the IDU and the next-PC source. A transaction-level
//   model (expected PC, instruction, status, latency, perf counts) is kept
//   here and compared against what the DUT presents.
// ---------------------------------------------------------------------------
module tb_ysyx_24090018_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        npc_valid_i;
  logic [31:0] npc_i;
  logic        npc_ready_o;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        imem_rsp_err_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic [1:0]  fetch_err_o;
`ifdef YSYX_24090018_IFU_PERF_EN
  logic [31:0] perf_fetch_cnt_o;
  logic [31:0] perf_stall_cnt_o;
`endif

  ysyx_24090018_ifu #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (32'h8000_0000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .npc_valid_i      (npc_valid_i),
    .npc_i            (npc_i),
    .npc_ready_o      (npc_ready_o),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .imem_rsp_err_i   (imem_rsp_err_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .pc_o             (pc_o),
    .fetch_err_o      (fetch_err_o)
`ifdef YSYX_24090018_IFU_PERF_EN
    ,
    .perf_fetch_cnt_o (perf_fetch_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc_now = 0;
  always @(posedge clk) cyc_now <= cyc_now + 1;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_stall;
  logic [31:0] m_fetch;

  // Observations recorded by run_txn
  logic        o_timeout, o_req_seen, o_addr_moved, o_wait_bad, o_out_moved, o_npc_bad;
  logic [31:0] o_addr, o_inst, o_pc, o_pc_after;
  logic [1:0]  o_err;
  int unsigned o_t_start, o_t_req, o_t_valid;

  // Drives one full fetch: request (with req_stall refusals), response after
  // rsp_lat idle cycles, OUT held for out_stall cycles with stray npc/rsp
  // activity, then the next PC after npc_delay cycles. Records observations.
  task automatic run_txn(input int req_stall, input int rsp_lat, input int out_stall,
                         input int npc_delay, input logic [31:0] data, input logic err,
                         input logic [31:0] stray_npc, input logic [31:0] nxt);
    int guard;
    int left;
    o_timeout = 0; o_req_seen = 0; o_addr_moved = 0; o_wait_bad = 0;
    o_out_moved = 0; o_npc_bad = 0; o_addr = '0; o_inst = '0; o_pc = '0;
    o_err = '0; o_pc_after = '0; o_t_start = cyc_now; o_t_req = 0; o_t_valid = 0;
    left = req_stall;
    guard = 0;
    while (!inst_valid_o && !o_timeout) begin
      if (imem_req_valid_o) begin
        if (!o_req_seen) begin
          o_req_seen = 1; o_addr = imem_addr_o; o_t_req = cyc_now;
        end else if (imem_addr_o !== o_addr) begin
          o_addr_moved = 1;
        end
        imem_req_ready_i = (left == 0);
        if (left > 0) left--;
      end
      @(negedge clk);
      if (imem_req_ready_i) begin
        imem_req_ready_i = 0;
        for (int i = 0; i <= rsp_lat; i++) begin
          if (imem_req_valid_o !== 1'b0 || inst_valid_o !== 1'b0 || npc_ready_o !== 1'b0)
            o_wait_bad = 1;
          imem_rsp_valid_i = (i == rsp_lat);
          imem_rsp_data_i  = (i == rsp_lat) ? data : $urandom;
          imem_rsp_err_i   = (i == rsp_lat) ? err : 1'($urandom);
          npc_valid_i      = 1'($urandom);
          npc_i            = $urandom;
          @(negedge clk);
        end
        imem_rsp_valid_i = 0;
        npc_valid_i = 0;
      end
      guard++;
      if (guard > 64) o_timeout = 1;
    end
    if (o_timeout) return;
    o_t_valid = cyc_now;
    o_inst = inst_o; o_pc = pc_o; o_err = fetch_err_o;
    for (int i = 0; i < out_stall; i++) begin
      inst_ready_i = 0; npc_valid_i = 1; npc_i = stray_npc;
      imem_rsp_valid_i = 1; imem_rsp_data_i = $urandom; imem_rsp_err_i = 1;
      @(negedge clk);
      if (inst_valid_o !== 1'b1 || inst_o !== o_inst || pc_o !== o_pc ||
          fetch_err_o !== o_err || npc_ready_o !== 1'b0 || imem_req_valid_o !== 1'b0)
        o_out_moved = 1;
    end
    npc_valid_i = 0; imem_rsp_valid_i = 0; inst_ready_i = 1;
    @(negedge clk);
    inst_ready_i = 0;
    for (int i = 0; i <= npc_delay; i++) begin
      if (npc_ready_o !== 1'b1 || inst_valid_o !== 1'b0 || imem_req_valid_o !== 1'b0)
        o_npc_bad = 1;
      npc_valid_i      = (i == npc_delay);
      npc_i            = (i == npc_delay) ? nxt : $urandom;
      imem_rsp_valid_i = (i != npc_delay) ? 1'($urandom) : 1'b0;
      imem_rsp_data_i  = $urandom;
      @(negedge clk);
    end
    npc_valid_i = 0; imem_rsp_valid_i = 0;
    o_pc_after = pc_o;
    if (npc_ready_o !== 1'b0) o_npc_bad = 1;
  endtask

  task automatic test_reset();
    npc_valid_i = 0; npc_i = '0; imem_req_ready_i = 0; imem_rsp_valid_i = 0;
    imem_rsp_data_i = '0; imem_rsp_err_i = 0; inst_ready_i = 0; rst = 0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({imem_req_valid_o, inst_valid_o, npc_ready_o} !== 3'b000) begin
      n_err++; $display("FAIL reset_valids: got %b expected 000", {imem_req_valid_o, inst_valid_o, npc_ready_o});
    end
    n_vec++;
    if ({pc_o, inst_o, fetch_err_o} !== {RST_PC, 32'h0, 2'b00}) begin
      n_err++; $display("FAIL reset_regs: got pc=%h inst=%h err=%b expected pc=%h inst=0 err=00", pc_o, inst_o, fetch_err_o, RST_PC);
    end
`ifdef YSYX_24090018_IFU_PERF_EN
    n_vec++;
    if ({perf_fetch_cnt_o, perf_stall_cnt_o} !== 64'h0) begin
      n_err++; $display("FAIL reset_perf: got %h/%h expected 0/0", perf_fetch_cnt_o, perf_stall_cnt_o);
    end
`endif
    rst = 1;
    @(negedge clk);
    n_vec++;
    if (imem_req_valid_o !== 1'b1 || imem_addr_o !== RST_PC) begin
      n_err++; $display("FAIL reset_first_req: got v=%b a=%h expected v=1 a=%h", imem_req_valid_o, imem_addr_o, RST_PC);
    end
    m_pc = RST_PC; m_stall = 1; m_fetch = 0;
  endtask

  task automatic test_basic();
    run_txn(0, 0, 0, 0, 32'h0000_0413, 1'b0, 32'h0, 32'h8000_0004);
    n_vec++;
    if (o_timeout !== 1'b0 || o_addr !== m_pc) begin
      n_err++; $display("FAIL basic_addr: got %h (timeout=%b) expected %h", o_addr, o_timeout, m_pc);
    end
    n_vec++;
    if (o_t_valid - o_t_req !== 2) begin
      n_err++; $display("FAIL basic_latency: got %0d expected 2", o_t_valid - o_t_req);
    end
    n_vec++;
    if ({o_inst, o_pc, o_err} !== {32'h0000_0413, m_pc, 2'b00}) begin
      n_err++; $display("FAIL basic_out: got inst=%h pc=%h err=%b expected inst=00000413 pc=%h err=00", o_inst, o_pc, o_err, m_pc);
    end
    m_stall += 1; m_fetch += 1; m_pc = 32'h8000_0004;
  endtask

  task automatic test_req_stall();
    run_txn(3, 1, 0, 1, 32'h1234_5678, 1'b0, 32'h0, 32'h8000_0008);
    n_vec++;
    if (o_addr !== m_pc || o_addr_moved !== 1'b0 || o_timeout !== 1'b0) begin
      n_err++; $display("FAIL req_stall_hold: got addr=%h moved=%b expected addr=%h moved=0", o_addr, o_addr_moved, m_pc);
    end
    n_vec++;
    if (o_t_valid - o_t_req !== 6 || o_wait_bad !== 1'b0) begin
      n_err++; $display("FAIL req_stall_latency: got %0d wait_bad=%b expected 6 wait_bad=0", o_t_valid - o_t_req, o_wait_bad);
    end
    m_stall += 3 + 1 + 1; m_fetch += 1; m_pc = 32'h8000_0008;
`ifdef YSYX_24090018_IFU_PERF_EN
    n_vec++;
    if (perf_stall_cnt_o !== m_stall || perf_fetch_cnt_o !== m_fetch) begin
      n_err++; $display("FAIL req_stall_perf: got stall=%0d fetch=%0d expected stall=%0d fetch=%0d", perf_stall_cnt_o, perf_fetch_cnt_o, m_stall, m_fetch);
    end
`endif
  endtask

  task automatic test_out_stall_stray();
    run_txn(0, 2, 4, 0, 32'hCAFE_0013, 1'b0, 32'h8000_0004, 32'h8000_0004);
    n_vec++;
    if (o_out_moved !== 1'b0 || o_inst !== 32'hCAFE_0013 || o_pc !== m_pc) begin
      n_err++; $display("FAIL out_stall_stable: got moved=%b inst=%h pc=%h expected moved=0 inst=cafe0013 pc=%h", o_out_moved, o_inst, o_pc, m_pc);
    end
    n_vec++;
    if (o_pc_after !== 32'h8000_0004 || o_npc_bad !== 1'b0) begin
      n_err++; $display("FAIL out_stall_npc: got pc=%h npc_bad=%b expected pc=80000004 npc_bad=0", o_pc_after, o_npc_bad);
    end
    m_stall += 3; m_fetch += 1; m_pc = 32'h8000_0004;
  endtask

  task automatic test_misaligned();
    run_txn(0, 0, 0, 0, 32'h0000_0093, 1'b0, 32'h0, 32'h8000_0006);
    n_vec++;
    if (o_addr !== 32'h8000_0004 || o_inst !== 32'h0000_0093) begin
      n_err++; $display("FAIL misalign_prev: got addr=%h inst=%h expected addr=80000004 inst=00000093", o_addr, o_inst);
    end
    m_stall += 1; m_fetch += 1; m_pc = 32'h8000_0006;
    run_txn(0, 0, 2, 0, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0010);
    n_vec++;
    if (o_req_seen !== 1'b0 || o_timeout !== 1'b0) begin
      n_err++; $display("FAIL misalign_noreq: got req_seen=%b timeout=%b expected 0/0", o_req_seen, o_timeout);
    end
    n_vec++;
    if ({o_inst, o_err, o_pc} !== {32'h0, 2'b10, 32'h8000_0006}) begin
      n_err++; $display("FAIL misalign_out: got inst=%h err=%b pc=%h expected inst=0 err=10 pc=80000006", o_inst, o_err, o_pc);
    end
    n_vec++;
    if (o_t_valid - o_t_start !== 1) begin
      n_err++; $display("FAIL misalign_latency: got %0d expected 1", o_t_valid - o_t_start);
    end
    m_stall += 1; m_fetch += 1; m_pc = 32'h8000_0010;
  endtask

  task automatic test_bus_err();
    run_txn(1, 0, 1, 0, 32'hDEAD_BEEF, 1'b1, 32'h0, 32'h8000_0020);
    n_vec++;
    if ({o_inst, o_err, o_pc} !== {32'hDEAD_BEEF, 2'b01, 32'h8000_0010}) begin
      n_err++; $display("FAIL bus_err_out: got inst=%h err=%b pc=%h expected inst=deadbeef err=01 pc=80000010", o_inst, o_err, o_pc);
    end
    m_stall += 2; m_fetch += 1; m_pc = 32'h8000_0020;
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    while (imem_req_valid_o !== 1'b1 && guard < 20) begin
      @(negedge clk); guard++;
    end
    n_vec++;
    if (imem_req_valid_o !== 1'b1 || imem_addr_o !== 32'h8000_0020) begin
      n_err++; $display("FAIL rstmid_req: got v=%b a=%h expected v=1 a=80000020", imem_req_valid_o, imem_addr_o);
    end
    imem_req_ready_i = 1;
    @(negedge clk);
    imem_req_ready_i = 0;
    rst = 0;
    @(negedge clk);
    n_vec++;
    if ({imem_req_valid_o, inst_valid_o, npc_ready_o} !== 3'b000 || pc_o !== RST_PC) begin
      n_err++; $display("FAIL rstmid_during: got valids=%b pc=%h expected 000 pc=%h", {imem_req_valid_o, inst_valid_o, npc_ready_o}, pc_o, RST_PC);
    end
`ifdef YSYX_24090018_IFU_PERF_EN
    n_vec++;
    if ({perf_fetch_cnt_o, perf_stall_cnt_o} !== 64'h0) begin
      n_err++; $display("FAIL rstmid_perf: got %h/%h expected 0/0", perf_fetch_cnt_o, perf_stall_cnt_o);
    end
`endif
    rst = 1;
    imem_rsp_valid_i = 1; imem_rsp_data_i = 32'hBAD0_BAD0; imem_rsp_err_i = 1;
    @(negedge clk);
    imem_rsp_valid_i = 0; imem_rsp_err_i = 0;
    n_vec++;
    if ({imem_req_valid_o, inst_valid_o} !== 2'b10 || imem_addr_o !== RST_PC ||
        inst_o !== 32'h0 || fetch_err_o !== 2'b00) begin
      n_err++; $display("FAIL rstmid_late_rsp: got v=%b iv=%b a=%h inst=%h err=%b expected v=1 iv=0 a=%h inst=0 err=00", imem_req_valid_o, inst_valid_o, imem_addr_o, inst_o, fetch_err_o, RST_PC);
    end
    m_pc = RST_PC; m_stall = 1; m_fetch = 0;
    run_txn(0, 0, 0, 0, 32'h0000_0517, 1'b0, 32'h0, RST_PC);
    n_vec++;
    if (o_addr !== RST_PC || {o_inst, o_err} !== {32'h0000_0517, 2'b00}) begin
      n_err++; $display("FAIL rstmid_refetch: got a=%h inst=%h err=%b expected a=%h inst=00000517 err=00", o_addr, o_inst, o_err, RST_PC);
    end
    m_stall += 1; m_fetch += 1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int rs, rl, os, nd;
      logic [31:0] data, nxt, exp_inst;
      logic err, aligned;
      logic [1:0] exp_err;
      int unsigned lat, exp_lat;
      rs = int'($urandom_range(0, 3)); rl = int'($urandom_range(0, 3));
      os = int'($urandom_range(0, 3)); nd = int'($urandom_range(0, 2));
      data = $urandom; err = ($urandom_range(0, 3) == 0);
      nxt = RST_PC + ($urandom_range(0, 1023) << 2);
      if ($urandom_range(0, 5) == 0) nxt = nxt | $urandom_range(1, 3);
      aligned  = (m_pc[1:0] == 2'b00);
      exp_inst = aligned ? data : 32'h0;
      exp_err  = aligned ? (err ? 2'b01 : 2'b00) : 2'b10;
      exp_lat  = aligned ? rs + rl + 2 : 1;
      run_txn(rs, rl, os, nd, data, err, $urandom, nxt);
      lat = o_t_valid - (aligned ? o_t_req : o_t_start);
      n_vec++;
      if (o_timeout !== 1'b0 || o_req_seen !== aligned || (aligned && o_addr !== m_pc)) begin
        n_err++; $display("FAIL rand_req[%0d]: got to=%b seen=%b a=%h expected to=0 seen=%b a=%h", n, o_timeout, o_req_seen, o_addr, aligned, m_pc);
      end
      n_vec++;
      if ({o_inst, o_err, o_pc} !== {exp_inst, exp_err, m_pc}) begin
        n_err++; $display("FAIL rand_out[%0d]: got inst=%h err=%b pc=%h expected inst=%h err=%b pc=%h", n, o_inst, o_err, o_pc, exp_inst, exp_err, m_pc);
      end
      n_vec++;
      if (lat !== exp_lat) begin
        n_err++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, exp_lat);
      end
      n_vec++;
      if ({o_addr_moved, o_wait_bad, o_out_moved, o_npc_bad} !== 4'b0000 || o_pc_after !== nxt) begin
        n_err++; $display("FAIL rand_protocol[%0d]: got flags=%b next_pc=%h expected flags=0000 next_pc=%h", n, {o_addr_moved, o_wait_bad, o_out_moved, o_npc_bad}, o_pc_after, nxt);
      end
      m_stall += aligned ? 32'(rs + rl + 1) : 32'd1;
      m_fetch += 1;
      m_pc = nxt;
`ifdef YSYX_24090018_IFU_PERF_EN
      n_vec++;
      if (perf_stall_cnt_o !== m_stall || perf_fetch_cnt_o !== m_fetch) begin
        n_err++; $display("FAIL rand_perf[%0d]: got stall=%0d fetch=%0d expected stall=%0d fetch=%0d", n, perf_stall_cnt_o, perf_fetch_cnt_o, m_stall, m_fetch);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_req_stall();
    test_out_stall_stray();
    test_misaligned();
    test_bus_err();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
